// File: rtl/conv2d_layer_scheduler_if.sv
// Signal bundle between the conv layer scheduler and its environment:
// the per-channel input FIFOs, the shared conv engine and the output store.
//
// Handshake semantics: rdreq is a pop strobe. It is high only when every FIFO
// is non-empty, and each high cycle consumes exactly one word from every
// channel. The same strobe is the engine's valid_in. engine_valid is a push
// from the engine with no backpressure. Each high cycle that the scheduler
// accepts is echoed on out_we in the same cycle. start, abort, pass_done and
// layer_done are single-cycle pulses.
interface conv2d_layer_scheduler_if #(
   parameter int CHANNELS = 16,
   parameter int FILT_W   = 5
);
   logic                start;
   logic                abort;
   logic [CHANNELS-1:0] fifo_empty;
   logic                rdreq;
   logic                engine_valid;
   logic                engine_clr_n;
   logic [FILT_W-1:0]   filter_sel;
   logic                out_we;
   logic                pass_done;
   logic                layer_done;
   logic                busy;
   logic                err_overrun;

   // master: the scheduler itself; slave: controller, FIFOs, engine, output store
   modport master (
      input  start, abort, fifo_empty, engine_valid,
      output rdreq, engine_clr_n, filter_sel, out_we, pass_done, layer_done,
             busy, err_overrun
   );

   modport slave (
      output start, abort, fifo_empty, engine_valid,
      input  rdreq, engine_clr_n, filter_sel, out_we, pass_done, layer_done,
             busy, err_overrun
   );
endinterface

// File: rtl/conv2d_layer_scheduler.sv
// Time-shares one 16-channel conv engine across NUM_FILTERS filter passes.
// Each pass clears the engine, meters (WIDTH+2)^2 padded pixels out of the
// FIFOs with one common read strobe, and counts WIDTH*WIDTH results before
// the next filter is selected.
module conv2d_layer_scheduler #(
   parameter int CHANNELS    = 16,
   parameter int WIDTH       = 56,
   parameter int NUM_FILTERS = 32,
   parameter int FILT_W      = 5
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   conv2d_layer_scheduler_if.master io_bus,
   output logic [2:0]               o_state
);

   localparam int IN_TOTAL  = (WIDTH + 2) * (WIDTH + 2);
   localparam int OUT_TOTAL = WIDTH * WIDTH;
   localparam int IN_W      = $clog2(IN_TOTAL + 1);
   localparam int OUT_W     = $clog2(OUT_TOTAL + 1);
   localparam logic [IN_W-1:0]   IN_LAST   = IN_W'(IN_TOTAL);
   localparam logic [OUT_W-1:0]  OUT_LAST  = OUT_W'(OUT_TOTAL);
   localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(NUM_FILTERS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_STREAM = 3'd2,
      S_DRAIN  = 3'd3,
      S_NEXT   = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [IN_W-1:0]     r_in_cnt;
   logic [IN_W-1:0]     w_in_cnt_nxt;
   logic [OUT_W-1:0]    r_out_cnt;
   logic [OUT_W-1:0]    w_out_cnt_nxt;
   logic [FILT_W-1:0]   r_filter_sel;
   logic                r_err;
   logic [CHANNELS-1:0] w_fifo_empty;
   logic                w_stream;
   logic                w_counting;
   logic                w_rdreq;
   logic                w_accept;
   logic                w_err_evt;
   logic                w_start_idle;

   assign w_fifo_empty = io_bus.fifo_empty;
   assign w_stream     = (r_state == S_STREAM);
   assign w_counting   = w_stream || (r_state == S_DRAIN);
   // One strobe for all lanes: a single empty FIFO stalls every channel.
   assign w_rdreq      = w_stream && !io_bus.abort && !(|w_fifo_empty) &&
                         (r_in_cnt < IN_LAST);
   // Results are only taken while a pass is in flight and still short of a full map.
   assign w_accept     = io_bus.engine_valid && w_counting && (r_out_cnt < OUT_LAST);
   assign w_err_evt    = io_bus.engine_valid && !w_accept;
   assign w_start_idle = (r_state == S_IDLE) && io_bus.start && !io_bus.abort;
   assign w_in_cnt_nxt  = r_in_cnt + {{(IN_W-1){1'b0}}, w_rdreq};
   assign w_out_cnt_nxt = r_out_cnt + {{(OUT_W-1){1'b0}}, w_accept};

   // State register.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic; abort overrides everything, a completed output map beats the input count.
   always_comb begin
      w_state_nxt = r_state;
      if (io_bus.abort) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:   if (io_bus.start) w_state_nxt = S_CLEAR;
            S_CLEAR:  w_state_nxt = S_STREAM;
            S_STREAM: begin
               if (w_out_cnt_nxt == OUT_LAST)    w_state_nxt = S_NEXT;
               else if (w_in_cnt_nxt == IN_LAST) w_state_nxt = S_DRAIN;
            end
            S_DRAIN:  if (w_out_cnt_nxt == OUT_LAST) w_state_nxt = S_NEXT;
            S_NEXT:   w_state_nxt = (r_filter_sel == FILT_LAST) ? S_DONE : S_CLEAR;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Pass counters, filter index and the sticky overrun flag.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_in_cnt     <= '0;
         r_out_cnt    <= '0;
         r_filter_sel <= '0;
         r_err        <= 1'b0;
      end else begin
         r_err <= (r_err && !w_start_idle) || w_err_evt;
         if (io_bus.abort) begin
            r_in_cnt     <= '0;
            r_out_cnt    <= '0;
            r_filter_sel <= '0;
         end else begin
            case (r_state)
               S_IDLE: if (io_bus.start) r_filter_sel <= '0;
               S_CLEAR: begin
                  r_in_cnt  <= '0;
                  r_out_cnt <= '0;
               end
               S_STREAM, S_DRAIN: begin
                  r_in_cnt  <= w_in_cnt_nxt;
                  r_out_cnt <= w_out_cnt_nxt;
               end
               S_NEXT: if (r_filter_sel != FILT_LAST) r_filter_sel <= r_filter_sel + FILT_W'(1);
               default: ;
            endcase
         end
      end
   end

   // Outputs decoded from registered state plus the live FIFO/engine inputs.
   always_comb begin
      io_bus.rdreq        = w_rdreq;
      io_bus.engine_clr_n = (r_state != S_CLEAR);
      io_bus.out_we       = w_accept;
      io_bus.pass_done    = (r_state == S_NEXT) && !io_bus.abort;
      io_bus.layer_done   = (r_state == S_DONE) && !io_bus.abort;
      io_bus.busy         = (r_state != S_IDLE);
      io_bus.filter_sel   = r_filter_sel;
      io_bus.err_overrun  = r_err;
      o_state             = r_state;
   end

endmodule

// File: tb/tb_conv2d_layer_scheduler.sv
// Bench for conv2d_layer_scheduler at WIDTH=4, NUM_FILTERS=3, CHANNELS=16:
// 36 padded reads and 16 results per pass, three passes per layer.
module tb_conv2d_layer_scheduler;

   localparam int CH    = 16;
   localparam int W     = 4;
   localparam int NF    = 3;
   localparam int FW    = 5;
   localparam int N_IN  = (W + 2) * (W + 2);
   localparam int N_OUT = W * W;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   conv2d_layer_scheduler_if #(.CHANNELS(CH), .FILT_W(FW)) bus ();
   logic [2:0] dbg_state;

   conv2d_layer_scheduler #(
      .CHANNELS(CH), .WIDTH(W), .NUM_FILTERS(NF), .FILT_W(FW)
   ) dut (
      .i_clk  (clk),
      .i_rst  (rst_n),
      .io_bus (bus),
      .o_state(dbg_state)
   );

   // ---------------- scoreboard counters ----------------
   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- engine model ----------------
   // Padded pixel k (row k/(W+2), col k%(W+2)) completes a 3x3 window when
   // row>=2 and col>=2, giving exactly W*W results per pass.
   int   eng_lat   = 1;
   int   eng_idx;
   logic eng_pend;
   logic inj_valid = 1'b0;
   logic eng_valid;

   function automatic logic qual(input int k);
      return (k < N_IN) && ((k / (W + 2)) >= 2) && ((k % (W + 2)) >= 2);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eng_idx  <= 0;
         eng_pend <= 1'b0;
      end else if (!bus.engine_clr_n) begin
         eng_idx  <= 0;
         eng_pend <= 1'b0;
      end else begin
         if (bus.rdreq) eng_idx <= eng_idx + 1;
         eng_pend <= bus.rdreq && qual(eng_idx);
      end
   end

   always_comb eng_valid = inj_valid || ((eng_lat == 0) ? (bus.rdreq && qual(eng_idx)) : eng_pend);
   assign bus.engine_valid = eng_valid;

   // ---------------- monitor / reference model ----------------
   logic [FW-1:0] exp_q[$];
   bit mon_en = 1'b0;
   int mon_reads, mon_outs, mon_passes, mon_layers, mon_bad_read;
   int mon_we_total, mon_valid_total, mon_clr;
   bit armed, inj_this_pass;
   int armed_cyc;

   always @(negedge clk) begin
      if (rst_n && mon_en) begin
         if (armed) begin
            armed_cyc++;
            if (bus.pass_done) begin
               // Same-cycle last read and last result goes straight to NEXT.
               chk("last_rd_to_pass_done", armed_cyc, (eng_lat == 0 || inj_this_pass) ? 1 : 2);
               armed = 1'b0;
            end else if (armed_cyc > 4) begin
               chk("pass_done_after_last_rd", 0, 1);
               armed = 1'b0;
            end
         end
         if (bus.rdreq) begin
            mon_reads++;
            if (bus.fifo_empty != '0) mon_bad_read++;
            if (mon_reads == N_IN) begin
               armed     = 1'b1;
               armed_cyc = 0;
            end
         end
         if (bus.out_we) begin
            mon_outs++;
            mon_we_total++;
         end
         if (eng_valid) mon_valid_total++;
         if (!bus.engine_clr_n) mon_clr++;
         if (bus.pass_done) begin
            chk("reads_per_pass", mon_reads, N_IN);
            chk("outs_per_pass", mon_outs, N_OUT);
            chk("exp_q_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("filter_sel_at_pass", bus.filter_sel, exp_q.pop_front());
            mon_reads     = 0;
            mon_outs      = 0;
            mon_passes++;
            inj_this_pass = 1'b0;
         end
         if (bus.layer_done) mon_layers++;
      end
   end

   task automatic begin_layer(input int lat);
      eng_lat = lat;
      exp_q.delete();
      for (int i = 0; i < NF; i++) exp_q.push_back(FW'(i));
      mon_reads = 0; mon_outs = 0; mon_passes = 0; mon_layers = 0;
      mon_bad_read = 0; mon_we_total = 0; mon_valid_total = 0; mon_clr = 0;
      armed = 1'b0; inj_this_pass = 1'b0;
      mon_en = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   // ---------------- table-driven layer runs ----------------
   typedef struct {
      int eng_lat;
      int stall_ch;
      int stall_at;
      int stall_len;
      int rand_empty;
      int inject_at;
      int exp_err;
      int exp_valids;
   } vec_t;

   vec_t vecs[6];

   task automatic run_layer(input vec_t v);
      int cyc = 0;
      int stall_left = 0;
      int rd_before = 0;
      bit stalled = 1'b0;
      bit injected = 1'b0;
      bit chk_frozen = 1'b0;
      logic [CH-1:0] e;
      bus.fifo_empty = '0;
      inj_valid = 1'b0;
      begin_layer(v.eng_lat);
      // CLEAR cycle
      chk("clear_clr_n", bus.engine_clr_n, 0);
      chk("clear_rdreq", bus.rdreq, 0);
      chk("clear_busy", bus.busy, 1);
      chk("clear_filter_sel", bus.filter_sel, 0);
      chk("err_cleared_on_start", bus.err_overrun, 0);
      tick();
      // first STREAM cycle: read possible 2 cycles after start
      chk("first_rdreq", bus.rdreq, 1);
      chk("stream_clr_n", bus.engine_clr_n, 1);
      while (mon_layers == 0 && cyc < 3000) begin
         inj_valid = 1'b0;
         if (chk_frozen) begin
            chk("stall_in_cnt_frozen", mon_reads, rd_before);
            chk_frozen = 1'b0;
         end
         if (!stalled && v.stall_len > 0 && mon_passes == 0 && mon_reads == v.stall_at) begin
            stalled    = 1'b1;
            stall_left = v.stall_len;
            rd_before  = mon_reads;
         end
         if (stall_left > 0) begin
            e = '0;
            e[v.stall_ch] = 1'b1;
            bus.fifo_empty = e;
            #1;
            chk("stall_rdreq", bus.rdreq, 0);
            stall_left--;
            if (stall_left == 0) chk_frozen = 1'b1;
         end else if (v.rand_empty != 0) begin
            e = '0;
            if ($urandom_range(0, 3) == 0) e[$urandom_range(0, CH - 1)] = 1'b1;
            bus.fifo_empty = e;
         end else begin
            bus.fifo_empty = '0;
         end
         if (v.inject_at >= 0 && !injected && mon_passes == 0 && mon_reads == v.inject_at) begin
            inj_valid     = 1'b1;
            injected      = 1'b1;
            inj_this_pass = 1'b1;
         end
         tick();
         cyc++;
      end
      inj_valid = 1'b0;
      bus.fifo_empty = '0;
      chk("layer_within_budget", cyc < 3000, 1);
      chk("layer_done_count", mon_layers, 1);
      chk("pass_done_count", mon_passes, NF);
      chk("exp_q_drained", exp_q.size(), 0);
      chk("idle_busy", bus.busy, 0);
      chk("filter_sel_holds", bus.filter_sel, NF - 1);
      chk("err_overrun", bus.err_overrun, v.exp_err);
      chk("out_we_total", mon_we_total, NF * N_OUT);
      chk("engine_valid_total", mon_valid_total, v.exp_valids);
      chk("clr_cycles", mon_clr, NF);
      chk("rd_while_empty", mon_bad_read, 0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rdreq"}, bus.rdreq, 0);
      chk({tag, "_clr_n"}, bus.engine_clr_n, 1);
      chk({tag, "_filter_sel"}, bus.filter_sel, 0);
      chk({tag, "_out_we"}, bus.out_we, 0);
      chk({tag, "_pass_done"}, bus.pass_done, 0);
      chk({tag, "_layer_done"}, bus.layer_done, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_err"}, bus.err_overrun, 0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main test ----------------
   initial begin
      int n;
      //            lat ch at len rnd inj err valids
      vecs[0] = '{1, 0, 0,  0, 0, -1, 0, 48};  // clean layer
      vecs[1] = '{1, 7, 12, 5, 0, -1, 0, 48};  // one FIFO empty for 5 cycles
      vecs[2] = '{1, 0, 0,  0, 0,  5, 1, 49};  // one extra engine result
      vecs[3] = '{0, 0, 0,  0, 0, -1, 0, 48};  // last read and last result together
      vecs[4] = '{1, 0, 0,  0, 1, -1, 0, 48};  // random FIFO starvation
      vecs[5] = '{0, 0, 0,  0, 1, -1, 0, 48};

      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.fifo_empty = '0;
      #3;
      chk_reset_outputs("reset");
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) run_layer(vecs[i]);

      // start while busy is ignored, then abort mid-pass
      bus.fifo_empty = '0;
      begin_layer(1);
      n = 0;
      while (!(mon_passes == 1 && mon_reads == 10) && n < 500) begin tick(); n++; end
      chk("reach_pass1", n < 500, 1);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("busy_start_ignored_sel", bus.filter_sel, 1);
      chk("busy_start_ignored_busy", bus.busy, 1);
      n = 0;
      while (mon_reads != 20 && n < 500) begin tick(); n++; end
      chk("reach_in_cnt_20", n < 500, 1);
      bus.abort = 1'b1;
      #1;
      chk("abort_cycle_rdreq", bus.rdreq, 0);
      chk("abort_cycle_pass_done", bus.pass_done, 0);
      tick();
      bus.abort = 1'b0;
      chk("abort_busy", bus.busy, 0);
      chk("abort_filter_sel", bus.filter_sel, 0);
      chk("abort_rdreq", bus.rdreq, 0);
      repeat (5) tick();
      chk("abort_no_more_passes", mon_passes, 1);
      chk("abort_no_layer_done", mon_layers, 0);
      chk("abort_stays_idle", bus.busy, 0);

      // asynchronous reset in the middle of a pass
      begin_layer(1);
      n = 0;
      while (mon_reads != 10 && n < 500) begin tick(); n++; end
      chk("reach_in_cnt_10", n < 500, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("async_reset");
      mon_en = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      run_layer(vecs[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
